// File: rtl/text_buffer_ctrl.sv
// Character-cell text buffer and cursor controller for the ASCII glyph renderer.
// Characters arrive over a valid/ready handshake and are written at the cursor
// into a COLS x ROWS character RAM. Newline, backspace, line wrap and row/screen
// clearing are handled here. A read port, independent of the write port, returns
// the code of the cell under pixel (x, y) one clock later.
// Optional feature macro: CURSOR_BLINK_EN. When it is defined, a blinking
// underscore (8'h5F) is overlaid on the cursor cell.
module text_buffer_ctrl #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter logic [7:0]  CLR_CHAR     = 8'h20,
  parameter int unsigned BLINK_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       clear,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [7:0] ascii_char,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLR_ALL = 2'd1,
    ST_CLR_ROW = 2'd2
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   sweep_q;   // CLR_ALL: linear cell address; CLR_ROW: column
  logic [6:0]      col_q;
  logic [4:0]      row_q;
  logic [7:0]      ascii_q;
  logic [7:0]      mem [CELLS];

  logic            accept;
  logic            is_nl;
  logic            is_bs;
  logic [4:0]      next_row;
  logic [AW-1:0]   row_base;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;

  logic            oor;
  logic [AW-1:0]   raddr;
  logic            cursor_hit;

  assign wr_ready   = (state_q == ST_IDLE) && !clear;
  assign accept     = wr_ready && wr_valid;
  assign busy       = (state_q != ST_IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign ascii_char = ascii_q;

  assign is_nl    = (wr_char == 8'h0D) || (wr_char == 8'h0A);
  assign is_bs    = (wr_char == 8'h08);
  assign next_row = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
  assign row_base = AW'(row_q) * AW'(COLS);

  // Write-port steering: clear sweeps own the port; otherwise the accepted character does.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = CLR_CHAR;
    case (state_q)
      ST_CLR_ALL: begin
        we    = 1'b1;
        waddr = sweep_q;
      end
      ST_CLR_ROW: begin
        we    = 1'b1;
        waddr = row_base + sweep_q;
      end
      default: begin
        if (accept) begin
          if (is_bs) begin
            if (col_q != 7'd0) begin
              we    = 1'b1;
              waddr = row_base + AW'(col_q) - AW'(1);
            end
          end else if (!is_nl) begin
            we    = 1'b1;
            waddr = row_base + AW'(col_q);
            wdata = wr_char;
          end
        end
      end
    endcase
  end

  // Controller FSM: clear sweeps, character decode and cursor movement.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLR_ALL;
      sweep_q <= '0;
      col_q   <= 7'd0;
      row_q   <= 5'd0;
    end else begin
      case (state_q)
        ST_CLR_ALL: begin
          if (sweep_q == AW'(CELLS - 1)) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
          end else begin
            sweep_q <= sweep_q + AW'(1);
          end
        end
        ST_CLR_ROW: begin
          if (sweep_q == AW'(COLS - 1)) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
          end else begin
            sweep_q <= sweep_q + AW'(1);
          end
        end
        default: begin
          // clear has priority over a character offered in the same cycle
          if (clear) begin
            col_q   <= 7'd0;
            row_q   <= 5'd0;
            sweep_q <= '0;
            state_q <= ST_CLR_ALL;
          end else if (wr_valid) begin
            sweep_q <= '0;
            if (is_nl) begin
              col_q   <= 7'd0;
              row_q   <= next_row;
              state_q <= ST_CLR_ROW;
            end else if (is_bs) begin
              if (col_q != 7'd0) begin
                col_q <= col_q - 7'd1;
              end
            end else if (col_q == 7'(COLS - 1)) begin
              col_q   <= 7'd0;
              row_q   <= next_row;
              state_q <= ST_CLR_ROW;
            end else begin
              col_q <= col_q + 7'd1;
            end
          end
        end
      endcase
    end
  end

  // Character RAM write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign oor   = (x >= 10'(COLS * 8)) || (y >= 10'(ROWS * 16));
  assign raddr = AW'(y[8:4]) * AW'(COLS) + AW'(x[9:3]);

`ifdef CURSOR_BLINK_EN
  logic [31:0] blink_cnt_q;
  logic        blink_on_q;

  // Blink phase generator: phase flips every BLINK_CYCLES clocks, starting "on".
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= 32'd0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == 32'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= 32'd0;
      blink_on_q  <= !blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 32'd1;
    end
  end

  assign cursor_hit = blink_on_q && (raddr == row_base + AW'(col_q));
`else
  // No blink overlay in this build; the term is constant false.
  assign cursor_hit = 1'b0 & (BLINK_CYCLES != 0);
`endif

  // Registered renderer read; a same-cycle write to the same cell returns the old code.
  always_ff @(posedge clk) begin
    if (reset) begin
      ascii_q <= 8'h00;
    end else if (oor) begin
      ascii_q <= 8'h00;
    end else if (cursor_hit) begin
      ascii_q <= 8'h5F;
    end else begin
      ascii_q <= mem[raddr];
    end
  end

endmodule
